// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with RW, RO and W1C registers for the rANS datapath.
// AW and W are held independently and commit together; reads complete with one cycle of latency.
module axi_lite_regbank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
   parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [ADDR_WIDTH-1:0]          awaddr_i,
   input  logic                           awvalid_i,
   output logic                           awready_o,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
   input  logic                           wvalid_i,
   output logic                           wready_o,
   output logic [1:0]                     bresp_o,
   output logic                           bvalid_o,
   input  logic                           bready_i,
   input  logic [ADDR_WIDTH-1:0]          araddr_i,
   input  logic                           arvalid_i,
   output logic                           arready_o,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   output logic [1:0]                     rresp_o,
   output logic                           rvalid_o,
   input  logic                           rready_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] sts_i,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] set_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int unsigned STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam int unsigned TOT_W    = NUM_REGS * DATA_WIDTH;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic                  aw_held_q, aw_held_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic [TOT_W-1:0]      regs_q, regs_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic                  commit;
   logic                  ar_hs;
   logic [IDX_W-1:0]      ar_idx;
   logic [DATA_WIDTH-1:0] wmask;
   logic                  unused_bits;

   // Address LSBs are ignored; sts_i/set_i bits of unrelated registers are don't-care.
   assign unused_bits = ^{awaddr_i[ADDR_LSB-1:0], araddr_i[ADDR_LSB-1:0], sts_i, set_i};

   assign awready_o  = !aw_held_q;
   assign wready_o   = !w_held_q;
   assign bvalid_o   = bvalid_q;
   assign bresp_o    = bresp_q;
   assign wr_pulse_o = wr_pulse_q;
   assign reg_o      = regs_q;
   assign rvalid_o   = rvalid_q;
   assign rdata_o    = rdata_q;
   assign rresp_o    = rresp_q;
   assign arready_o  = !rvalid_q || rready_i;

   always_comb begin : strobe_mask
      wmask = '0;
      for (int b = 0; b < STRB_W; b++) wmask[b*8 +: 8] = {8{wstrb_q[b]}};
   end

   // Write path: independent AW/W holds, commit, then W1C hardware set (set wins over clear).
   always_comb begin : write_path
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      commit     = aw_held_q && w_held_q && !bvalid_q;

      if (bvalid_q && bready_i) bvalid_d = 1'b0;
      if (awvalid_i && !aw_held_q) begin
         aw_held_d = 1'b1;
         aw_idx_d  = awaddr_i[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (wvalid_i && !w_held_q) begin
         w_held_d = 1'b1;
         wdata_d  = wdata_i;
         wstrb_d  = wstrb_i;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) begin
               bresp_d       = RESP_OKAY;
               wr_pulse_d[i] = 1'b1;
               if (W1C_MASK[i])
                  regs_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i*DATA_WIDTH +: DATA_WIDTH] & ~(wdata_q & wmask);
               else
                  regs_d[i*DATA_WIDTH +: DATA_WIDTH] = (regs_q[i*DATA_WIDTH +: DATA_WIDTH] & ~wmask) | (wdata_q & wmask);
            end
         end
      end

      for (int i = 0; i < NUM_REGS; i++) begin
         if (W1C_MASK[i] && !RO_MASK[i])
            regs_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_d[i*DATA_WIDTH +: DATA_WIDTH] | set_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Read path: capture data at the AR handshake, hold it while the master stalls.
   always_comb begin : read_path
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      ar_idx   = araddr_i[ADDR_WIDTH-1:ADDR_LSB];
      ar_hs    = arvalid_i && arready_o;

      if (rvalid_q && rready_i) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
               rresp_d = RESP_OKAY;
               rdata_d = RO_MASK[i] ? sts_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         regs_q     <= RESET_VALUE;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_lite_regbank;

   localparam int NR = 16;
   localparam logic [NR-1:0]    RO  = 16'h0001;
   localparam logic [NR-1:0]    W1C = 16'h0008;
   localparam logic [NR*32-1:0] RV  = (512'h0 | 512'hAAAAAAAA) << 64;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [7:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
   logic [1:0]  bresp_o, rresp_o;
   logic [31:0] rdata_o;
   logic [NR*32-1:0] reg_o;
   logic [NR*32-1:0] sts = '0, set_v = '0;
   logic [NR-1:0]    wr_pulse_o;

   int n_cmp = 0;
   int n_bad = 0;

   axi_lite_regbank #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR),
      .RO_MASK(RO), .W1C_MASK(W1C), .RESET_VALUE(RV)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_o),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
      .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
      .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_o),
      .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready),
      .reg_o(reg_o), .sts_i(sts), .set_i(set_v), .wr_pulse_o(wr_pulse_o)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [NR];
   int          aw_q [$];
   logic [31:0] wd_q [$];
   logic [3:0]  ws_q [$];
   logic        m_bvalid, m_rvalid;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata;
   logic [NR-1:0] m_pulse;
   logic        mdl_live = 1'b0;

   always @(posedge aclk) begin
      if (!aresetn) begin
         aw_q.delete(); wd_q.delete(); ws_q.delete();
         m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_pulse = 0;
         for (int i = 0; i < NR; i++) m_regs[i] = RV[i*32 +: 32];
         mdl_live = 1'b1;
      end else begin
         automatic bit aw_free = (aw_q.size() == 0);
         automatic bit w_free  = (wd_q.size() == 0);
         automatic bit ar_take = arvalid && (!m_rvalid || rready);
         automatic int ri = int'(araddr[7:2]);
         automatic bit do_commit = (aw_q.size() > 0) && (wd_q.size() > 0) && !m_bvalid;
         // read sees register values before this edge's write
         if (ar_take) begin
            m_rvalid = 1;
            if (ri >= NR) begin m_rdata = 0; m_rresp = 2'b10; end
            else begin
               m_rresp = 2'b00;
               m_rdata = RO[ri] ? sts[ri*32 +: 32] : m_regs[ri];
            end
         end else if (m_rvalid && rready) m_rvalid = 0;

         if (m_bvalid && bready) m_bvalid = 0;
         m_pulse = '0;
         if (do_commit) begin
            automatic int wi = aw_q.pop_front();
            automatic logic [31:0] d = wd_q.pop_front();
            automatic logic [3:0]  s = ws_q.pop_front();
            m_bvalid = 1;
            if (wi >= NR || RO[wi]) m_bresp = 2'b10;
            else begin
               m_bresp = 2'b00;
               m_pulse[wi] = 1'b1;
               for (int b = 0; b < 4; b++) if (s[b]) begin
                  if (W1C[wi]) m_regs[wi][b*8 +: 8] = m_regs[wi][b*8 +: 8] & ~d[b*8 +: 8];
                  else         m_regs[wi][b*8 +: 8] = d[b*8 +: 8];
               end
            end
         end
         for (int i = 0; i < NR; i++) if (W1C[i]) m_regs[i] = m_regs[i] | set_v[i*32 +: 32];

         if (awvalid && aw_free) aw_q.push_back(int'(awaddr[7:2]));
         if (wvalid && w_free) begin wd_q.push_back(wdata); ws_q.push_back(wstrb); end
      end
   end

   // Compare DUT against model mid-cycle, away from the active edge.
   always @(negedge aclk) begin
      if (mdl_live && aresetn) begin
         chk("awready", awready_o, aw_q.size() == 0);
         chk("wready", wready_o, wd_q.size() == 0);
         chk("arready", arready_o, !m_rvalid || rready);
         chk("bvalid", bvalid_o, m_bvalid);
         if (m_bvalid) chk("bresp", bresp_o, m_bresp);
         chk("rvalid", rvalid_o, m_rvalid);
         if (m_rvalid) begin
            chk("rdata", rdata_o, m_rdata);
            chk("rresp", rresp_o, m_rresp);
         end
         chk("wr_pulse", wr_pulse_o, m_pulse);
         for (int i = 0; i < NR; i++) if (!RO[i]) chk($sformatf("reg%0d", i), reg_o[i*32 +: 32], m_regs[i]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge aclk); #1;
   endtask

   task automatic timeout(input string nm);
      n_cmp++; n_bad++;
      $display("FAIL %s: no handshake within bound", nm);
   endtask

   task automatic axi_write(input bit do_aw, input bit do_w, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      int  g;
      bit  aw_hs, w_hs;
      g = 0;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = do_aw; wvalid = do_w;
      while ((awvalid || wvalid) && g < 30) begin
         aw_hs = awvalid && awready_o;
         w_hs  = wvalid && wready_o;
         tick();
         if (aw_hs) awvalid = 0;
         if (w_hs)  wvalid = 0;
         g++;
      end
      if (awvalid || wvalid) begin timeout("write_hs"); awvalid = 0; wvalid = 0; end
   endtask

   task automatic wait_b(output logic [1:0] resp, output logic [NR-1:0] pulse);
      int g;
      g = 0;
      while (!bvalid_o && g < 30) begin tick(); g++; end
      if (!bvalid_o) timeout("bvalid");
      resp = bresp_o; pulse = wr_pulse_o;
      if (bready) tick();
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      int g;
      bit hs;
      g = 0; hs = 0;
      araddr = a; arvalid = 1;
      while (!hs && g < 30) begin
         hs = arready_o;
         tick();
         g++;
      end
      arvalid = 0;
      if (!hs) timeout("ar_hs");
      chk("read_rvalid", rvalid_o, 1'b1);
      d = rdata_o; r = rresp_o;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [NR-1:0] p;
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_exp  [4];
      sts[0 +: 32] = 32'hCAFE0001;
      sts[32 +: 32] = 32'h0BAD0BAD;
      repeat (3) tick();
      aresetn = 1;
      tick();
      // reset state
      chk("rst_awready", awready_o, 1); chk("rst_wready", wready_o, 1);
      chk("rst_arready", arready_o, 1); chk("rst_bvalid", bvalid_o, 0);
      chk("rst_rvalid", rvalid_o, 0);   chk("rst_rdata", rdata_o, 0);
      chk("rst_bresp", bresp_o, 0);     chk("rst_rresp", rresp_o, 0);
      chk("rst_pulse", wr_pulse_o, 0);  chk("rst_reg2", reg_o[64 +: 32], 32'hAAAAAAAA);

      // same-cycle AW+W, latency and pulse
      axi_write(1, 1, 8'h04, 32'hDEADBEEF, 4'hF);
      chk("t1_b_early", bvalid_o, 0);
      tick();
      chk("t1_bvalid", bvalid_o, 1); chk("t1_bresp", bresp_o, 2'b00);
      chk("t1_pulse", wr_pulse_o, 16'h0002); chk("t1_reg1", reg_o[32 +: 32], 32'hDEADBEEF);
      tick();
      chk("t1_pulse_end", wr_pulse_o, 0); chk("t1_b_done", bvalid_o, 0);
      axi_read(8'h04, d, r);
      chk("t1_rdata", d, 32'hDEADBEEF); chk("t1_rresp", r, 2'b00);
      tick();

      // W three cycles ahead of AW, partial strobe
      axi_write(0, 1, 8'h00, 32'h12345678, 4'h3);
      tick(); tick();
      chk("t2_wready_low", wready_o, 0);
      axi_write(1, 0, 8'h08, 32'h0, 4'h0);
      chk("t2_wready_still_low", wready_o, 0);
      wait_b(r, p);
      chk("t2_bresp", r, 2'b00); chk("t2_reg2", reg_o[64 +: 32], 32'hAAAA5678);

      // W1C with hardware set
      set_v[96 +: 32] = 32'h5; tick(); set_v = '0;
      axi_read(8'h0C, d, r); chk("t3_set", d, 32'h5);
      tick();
      axi_write(1, 1, 8'h0C, 32'h1, 4'hF); wait_b(r, p);
      chk("t3_clr_pulse", p, 16'h0008);
      axi_read(8'h0C, d, r); chk("t3_clr", d, 32'h4);
      tick();
      axi_write(1, 1, 8'h0C, 32'h4, 4'hF);
      set_v[96 +: 32] = 32'h4; tick(); set_v = '0;
      wait_b(r, p);
      axi_read(8'h0C, d, r); chk("t3_set_wins", d, 32'h4);
      tick();

      // RO and illegal accesses
      axi_write(1, 1, 8'h00, 32'hFFFFFFFF, 4'hF); wait_b(r, p);
      chk("t4_ro_bresp", r, 2'b10); chk("t4_ro_pulse", p, 16'h0);
      axi_read(8'h00, d, r); chk("t4_ro_rdata", d, 32'hCAFE0001); chk("t4_ro_rresp", r, 2'b00);
      tick();
      axi_read(8'h40, d, r); chk("t4_ill_rdata", d, 32'h0); chk("t4_ill_rresp", r, 2'b10);
      tick();
      axi_write(1, 1, 8'h40, 32'h1, 4'hF); wait_b(r, p);
      chk("t4_ill_bresp", r, 2'b10); chk("t4_ill_pulse", p, 16'h0);

      // B back-pressure with a second write queued
      bready = 0;
      axi_write(1, 1, 8'h10, 32'h11111111, 4'hF);
      tick();
      chk("t5_b1", bvalid_o, 1);
      axi_write(1, 1, 8'h14, 32'h22222222, 4'hF);
      tick(); tick();
      chk("t5_awready_low", awready_o, 0); chk("t5_wready_low", wready_o, 0);
      chk("t5_b_hold", bvalid_o, 1); chk("t5_bresp_hold", bresp_o, 2'b00);
      chk("t5_reg5_old", reg_o[160 +: 32], 32'h0);
      bready = 1;
      tick();
      chk("t5_b_gap", bvalid_o, 0);
      tick();
      chk("t5_b2", bvalid_o, 1); chk("t5_pulse2", wr_pulse_o, 16'h0020);
      chk("t5_reg5", reg_o[160 +: 32], 32'h22222222);
      tick();

      // back-to-back reads
      b2b_addr[0] = 32'h04; b2b_exp[0] = 32'hDEADBEEF;
      b2b_addr[1] = 32'h08; b2b_exp[1] = 32'hAAAA5678;
      b2b_addr[2] = 32'h0C; b2b_exp[2] = 32'h4;
      b2b_addr[3] = 32'h40; b2b_exp[3] = 32'h0;
      arvalid = 1;
      for (int k = 0; k < 4; k++) begin
         araddr = b2b_addr[k][7:0];
         tick();
         chk($sformatf("t6_b2b_rvalid%0d", k), rvalid_o, 1);
         chk($sformatf("t6_b2b_rdata%0d", k), rdata_o, b2b_exp[k]);
      end
      arvalid = 0;
      tick();
      chk("t6_b2b_idle", rvalid_o, 0);

      // read stall plus pending B, then reset mid-transaction
      bready = 0;
      axi_write(1, 1, 8'h18, 32'h33333333, 4'hF);
      tick();
      rready = 0; araddr = 8'h04; arvalid = 1;
      tick();
      araddr = 8'h08;
      for (int k = 0; k < 3; k++) begin
         chk("t6_stall_arready", arready_o, 0);
         chk("t6_stall_rdata", rdata_o, 32'hDEADBEEF);
         tick();
      end
      aresetn = 0; arvalid = 0;
      tick();
      chk("t7_rvalid", rvalid_o, 0); chk("t7_bvalid", bvalid_o, 0);
      chk("t7_reg6", reg_o[192 +: 32], 32'h0); chk("t7_reg1", reg_o[32 +: 32], 32'h0);
      chk("t7_reg2", reg_o[64 +: 32], 32'hAAAAAAAA); chk("t7_awready", awready_o, 1);
      aresetn = 1; rready = 1; bready = 1;
      tick(); tick();
      axi_read(8'h04, d, r); chk("t7_post_read", d, 32'h0);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
